// File: rtl/goto_range_checker.sv
// rtl/goto_range_checker.sv - run-time monitor for trigger |-> ##DELAY hit[->MIN:MAX] ##1 done
module goto_range_checker #(
    parameter int DELAY     = 2,
    parameter int MIN_HITS  = 2,
    parameter int MAX_HITS  = 5,
    parameter int TIMEOUT   = 0,
    parameter int NUM_SLOTS = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger_i,
    input  logic                 hit_i,
    input  logic                 done_i,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic                 fail_timeout_o,
    output logic                 overflow_o,
    output logic [NUM_SLOTS-1:0] busy_o,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o
);

    // Window counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WIN_LAST  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    WAIT_INIT = 8'(DELAY - 1);
    localparam logic [7:0]    MIN_K     = 8'(MIN_HITS);
    localparam logic [7:0]    MAX_K     = 8'(MAX_HITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HUNT  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t          state_q [NUM_SLOTS];
    state_t          state_d [NUM_SLOTS];
    logic [7:0]      dly_q   [NUM_SLOTS];
    logic [7:0]      dly_d   [NUM_SLOTS];
    logic [7:0]      hits_q  [NUM_SLOTS];
    logic [7:0]      hits_d  [NUM_SLOTS];
    logic [TW-1:0]   win_q   [NUM_SLOTS];
    logic [TW-1:0]   win_d   [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] dec_pass;
    logic [NUM_SLOTS-1:0] dec_fail;
    logic [NUM_SLOTS-1:0] dec_tmo;
    logic                 overflow_d;

    logic [3:0]           n_pass;
    logic [3:0]           n_fail;
    logic [CNT_W:0]       pass_sum;
    logic [CNT_W:0]       fail_sum;
    logic [CNT_W-1:0]     pass_cnt_d;
    logic [CNT_W-1:0]     fail_cnt_d;

    // Slot state and registered report pulses/counters; reset drops any open attempt silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= S_IDLE;
                dly_q[i]   <= '0;
                hits_q[i]  <= '0;
                win_q[i]   <= '0;
            end
            pass_o         <= 1'b0;
            fail_o         <= 1'b0;
            fail_timeout_o <= 1'b0;
            overflow_o     <= 1'b0;
            pass_cnt_o     <= '0;
            fail_cnt_o     <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                dly_q[i]   <= dly_d[i];
                hits_q[i]  <= hits_d[i];
                win_q[i]   <= win_d[i];
            end
            pass_o         <= |dec_pass;
            fail_o         <= |dec_fail;
            fail_timeout_o <= |dec_tmo;
            overflow_o     <= overflow_d;
            pass_cnt_o     <= pass_cnt_d;
            fail_cnt_o     <= fail_cnt_d;
        end
    end

    // Allocation to the lowest idle slot plus per-slot next state and decisions.
    always_comb begin : next_state
        logic taken;
        taken = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i]  = state_q[i];
            dly_d[i]    = dly_q[i];
            hits_d[i]   = hits_q[i];
            win_d[i]    = win_q[i];
            dec_pass[i] = 1'b0;
            dec_fail[i] = 1'b0;
            dec_tmo[i]  = 1'b0;
            case (state_q[i])
                S_IDLE: begin
                    if (trigger_i && !taken) begin
                        taken     = 1'b1;
                        hits_d[i] = '0;
                        win_d[i]  = '0;
                        if (DELAY == 1) begin
                            state_d[i] = S_HUNT;
                        end else begin
                            state_d[i] = S_WAIT;
                            dly_d[i]   = WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dly_q[i] == 8'd1) begin
                        state_d[i] = S_HUNT;
                    end else begin
                        dly_d[i] = dly_q[i] - 8'd1;
                    end
                end
                S_HUNT: begin
                    // done is meaningless here: it only counts the cycle after a qualifying hit
                    if (hit_i) begin
                        hits_d[i] = hits_q[i] + 8'd1;
                        if (hits_q[i] + 8'd1 >= MIN_K) begin
                            state_d[i] = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (done_i) begin
                        dec_pass[i] = 1'b1;
                    end else if (hits_q[i] < MAX_K) begin
                        if (hit_i) begin
                            hits_d[i] = hits_q[i] + 8'd1;
                        end else begin
                            state_d[i] = S_HUNT;
                        end
                    end else begin
                        dec_fail[i] = 1'b1;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
            if (state_q[i] == S_HUNT || state_q[i] == S_CHECK) begin
                // A regular decision on the last window cycle beats the timeout.
                if (!dec_pass[i] && !dec_fail[i] && (TIMEOUT > 0) && (win_q[i] == WIN_LAST)) begin
                    dec_fail[i] = 1'b1;
                    dec_tmo[i]  = 1'b1;
                end
                win_d[i] = win_q[i] + TW'(1);
                if (dec_pass[i] || dec_fail[i]) begin
                    state_d[i] = S_IDLE;
                end
            end
        end
        overflow_d = trigger_i && !taken;
    end

    // Busy flags and saturating counter updates from this cycle's decisions.
    always_comb begin
        n_pass = '0;
        n_fail = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            busy_o[i] = (state_q[i] != S_IDLE);
            n_pass    = n_pass + 4'(dec_pass[i]);
            n_fail    = n_fail + 4'(dec_fail[i]);
        end
        pass_sum   = {1'b0, pass_cnt_o} + (CNT_W+1)'(n_pass);
        fail_sum   = {1'b0, fail_cnt_o} + (CNT_W+1)'(n_fail);
        pass_cnt_d = pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
        fail_cnt_d = fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
    end

endmodule

// File: doc/goto_range_checker.md
Name: goto_range_checker

Overview:
- Synthesizable, parametrised run-time monitor for the property "trigger |-> ##DELAY hit[->MIN_HITS:MAX_HITS] ##1 done" on one clock domain.
- Carries the transmit/receive/complete goto-range check into RTL, so it runs on silicon and in emulation as well as in simulation.
- Adds overlapping attempts (NUM_SLOTS engines), an optional timeout, and saturating pass/fail counters.
- Sits beside the transmitter/receiver datapath; observes only, never drives it.

Parameters:
- DELAY, 2, cycles from trigger sample to first hit-sampling cycle; legal 1..255.
- MIN_HITS, 2, minimum hit count before done is accepted; legal 1..MAX_HITS.
- MAX_HITS, 5, maximum hit count; legal MIN_HITS..255.
- TIMEOUT, 0, window length in cycles counted from the first sampling cycle; 0 disables the timeout.
- NUM_SLOTS, 2, number of concurrent attempt engines; legal 1..8.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clk, input, 1, single clock; all sampling on its rising edge.
- rst, input, 1, synchronous active-high reset.
- trigger_i, input, 1, antecedent (transmitter).
- hit_i, input, 1, goto-repeated event (receiver).
- done_i, input, 1, completion event.
- pass_o, output, 1, one-cycle pulse: at least one attempt passed.
- fail_o, output, 1, one-cycle pulse: at least one attempt failed.
- fail_timeout_o, output, 1, one-cycle pulse: at least one failure was a timeout.
- overflow_o, output, 1, one-cycle pulse: trigger dropped because all slots were busy.
- busy_o, output, NUM_SLOTS, per-slot active flag.
- pass_cnt_o, output, CNT_W, saturating count of passed attempts.
- fail_cnt_o, output, CNT_W, saturating count of failed attempts (timeouts included).

Behaviour:
- Reset: on rst high at a clock edge, all slots go IDLE and every output is cleared to 0 (pulses, busy_o, both counters). Reset mid-attempt discards the attempt silently: no pass or fail is reported.
- Slot FSM states:
  - IDLE.
  - WAIT: delay countdown.
  - HUNT: counting hits.
  - CHECK: cycle after a qualifying hit.
- IDLE -> WAIT: trigger_i sampled high, slot is the lowest-index IDLE slot. Only one slot allocates per cycle. If no slot is IDLE, the trigger is dropped and overflow_o pulses on the next cycle.
- First sampling cycle: with trigger at cycle t, the first hit-sampling cycle is t+DELAY. WAIT lasts DELAY-1 cycles. For DELAY=1 the slot enters HUNT directly.
- HUNT:
  - hit_i high increments hits (which includes the cycle t+DELAY itself).
  - If the new count is >= MIN_HITS, go to CHECK.
  - done_i is ignored while count < MIN_HITS.
- CHECK (the cycle after the k-th hit, MIN_HITS <= k <= MAX_HITS):
  - done_i high: PASS. done_i has priority over a simultaneous hit_i.
  - Else if hit_i high and k < MAX_HITS: k+1; stay in CHECK if k+1 <= MAX_HITS.
  - Else if hit_i low and k < MAX_HITS: return to HUNT.
  - Else (k == MAX_HITS, done_i low): FAIL.
- Timeout: if TIMEOUT > 0 and no decision has been made by the sampling cycle t+DELAY+TIMEOUT-1, that cycle decides FAIL with the timeout flag set. A PASS or FAIL decided in the same cycle takes precedence over the timeout.
- Reporting latency:
  - A decision on the sample at cycle d produces pass_o/fail_o at cycle d+1 (registered) and returns the slot to IDLE.
  - That slot can accept a new trigger in cycle d+1.
  - busy_o is high from the cycle after allocation through cycle d.
- Simultaneous decisions: pulses are ORed. Each counter adds the number of slots deciding that outcome in that cycle and saturates at all-ones.
- A trigger arriving while another slot is active always opens a new independent attempt; attempts never merge.

Test Plan:
- Pass at MIN: defaults, trigger at cycle 0 only, hit at cycles 2 and 4, done at 5 -> pass_o=1 at cycle 6; pass_cnt_o=1; fail_o stays 0.
- Early done ignored: hit at 2, done+hit at 3, done at 4 -> pass_o at cycle 5 (done at 3 ignored since count=1 there; hit at 3 makes count 2).
- MAX exceeded: hit at cycles 2..6, done low at 7 and high at 8 -> fail_o at cycle 8; fail_timeout_o=0; fail_cnt_o=1.
- Timeout: TIMEOUT=16, one hit at 2, done pulsed at 3 -> fail_o and fail_timeout_o at cycle 18.
- Overflow: NUM_SLOTS=2, trigger high at cycles 0, 1, 2 -> busy_o=2'b11 at cycle 2; overflow_o at cycle 3; slots 0/1 evaluate independently (windows start at 2 and 3).
- Reset mid-attempt: trigger at 0, hit at 2, rst at 3 -> all outputs 0 from cycle 4; done at 5 gives no pass; counters remain 0.
